uart_txrx_core: RTL and testbench
=================================

// Module: uart_txrx_core
// PURPOSE
// - 8N1 UART byte transmitter and receiver pair; no parity, no flow control.
// - Serialises one byte per handshake onto tx_serial.
// - Deserialises rx_serial into bytes with a one-cycle valid strobe.
// - Sits between a command/data FSM (e.g. Zigbee AT-command controller) and the radio module's UART pins.
// PARAMETERS
// - CLKS_PER_BIT  10416  clk cycles per bit (CLOCK_FREQ/BAUD); legal range >= 4; 10416 = 100 MHz / 9600 baud.
// PORTS
// - clk            in   1  system clock; all logic on rising edge.
// - reset_n        in   1  asynchronous, active-low reset.
// - tx_data_valid  in   1  level request: send tx_byte.
// - tx_byte        in   8  byte to transmit; captured when request accepted.
// - tx_active      out  1  high from accept through end of stop bit.
// - tx_serial      out  1  serial line to module RX; idle high.
// - tx_done        out  1  high after stop bit ends; held until next accept.
// - rx_serial      in   1  serial line from module TX; asynchronous to clk.
// - rx_data_valid  out  1  one-cycle strobe: rx_byte holds a new byte.
// - rx_byte        out  8  last received byte; held until overwritten.
// - rx_frame_err   out  1  one-cycle strobe when the stop bit samples low.
// BEHAVIOUR
// - Reset values: tx_serial=1; tx_active=0; tx_done=0; rx_data_valid=0; rx_byte=0x00; rx_frame_err=0.
// - Reset values: both FSMs in IDLE, counters 0. Reset mid-frame aborts the frame immediately; tx_serial returns to 1.
// - Frame format: start(0), d0..d7 LSB first, stop(1). Each bit lasts exactly CLKS_PER_BIT cycles.
// - TX FSM states: IDLE, START, DATA, STOP.
//   - IDLE: tx_serial=1. tx_data_valid=1 samples tx_byte, then tx_active<=1, tx_done<=0, go START.
//   - Accept -> tx_serial low on the next edge.
//   - Requests are ignored while not in IDLE; tx_byte changes mid-frame do not affect the frame.
//   - START: drive 0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
//   - DATA: drive bit[idx] for CLKS_PER_BIT cycles; idx 7 -> STOP.
//   - STOP: drive 1 for CLKS_PER_BIT cycles; then tx_active<=0, tx_done<=1, go IDLE.
//   - tx_done is a sticky level, not a pulse; it clears only on the next accept.
//   - If tx_data_valid is still high on return to IDLE, a new frame starts; the caller drops valid once tx_active is seen.
//   - Frame length = 10*CLKS_PER_BIT cycles from accept to tx_done rise.
// - RX path: rx_serial passes through a 2-flop synchroniser (2-cycle latency) before use.
// - RX FSM states: IDLE, START, DATA, STOP.
//   - IDLE: synchronised line 0 -> START, counter cleared.
//   - START: at count CLKS_PER_BIT/2 (integer division), re-sample.
//     - Sample 0 -> DATA, counter reset.
//     - Sample 1 -> glitch, return to IDLE with no output.
//   - DATA: sample every CLKS_PER_BIT cycles (mid-bit) into shift register, LSB first; after 8 samples -> STOP.
//   - STOP: after CLKS_PER_BIT cycles, sample the line.
//     - Sample 1 -> rx_byte<=data, rx_data_valid=1 for exactly one cycle.
//     - Sample 0 -> rx_frame_err=1 for one cycle; rx_byte unchanged.
//     - Either case -> IDLE immediately (mid-stop), so back-to-back frames are received without loss.
// - TX and RX are fully independent; simultaneous send and receive is legal.
// - Counter width: $clog2(CLKS_PER_BIT); compare against CLKS_PER_BIT-1 for terminal count. Bit index 3 bits, no wrap beyond 7.
// STRUCTURE
// - Shared package uart_pkg: FSM state enum (IDLE/START/DATA/STOP), DATA_BITS=8 constant.
// - Sub-modules uart_tx_core and uart_rx_core, instantiated side by side.
//   - Each carries the CLKS_PER_BIT parameter; the top only wires them.
// TESTING
// Benches use CLKS_PER_BIT=16.
// 1. Loopback tx_serial->rx_serial; send 0xA5 -> one rx_data_valid strobe, rx_byte=0xA5.
//    Same test: tx_done rises 160 cycles after accept.
// 2. Send 0x00, then 0xFF, then 0x01 back-to-back, each on tx_done -> three strobes, bytes in order; line bit pattern checked per bit.
// 3. 3-cycle low glitch on idle rx_serial -> no rx_data_valid, no rx_frame_err; a following valid frame 0x3C is received.
// 4. Frame with stop bit forced 0 -> rx_frame_err strobe, no rx_data_valid, rx_byte keeps previous value.
// 5. tx_data_valid held high 50 cycles, byte changed at cycle 5.
//    -> one frame, original byte.
//    -> tx_active=1 for 160 cycles.
// 6. reset_n low at bit 4 of a TX frame and an RX frame.
//    -> tx_serial=1, all outputs at reset values.
//    -> next 0x5A frame after release is sent and received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART transmitter and receiver cores.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: synchronised input, mid-bit sampling, valid/frame-error strobes.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx_serial,
  output logic                 rx_data_valid,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 rx_frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  uart_state_e          state, state_nxt;
  logic [1:0]           sync;
  logic                 rx_s;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 bit_end, shift_en, byte_ok, byte_err;

  assign rx_s    = sync[1];
  assign bit_end = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rx_s) state_nxt = START;
      START:   if (cnt == CNT_HALF) state_nxt = rx_s ? IDLE : DATA;
      DATA:    if (bit_end && (idx == IDX_LAST)) state_nxt = STOP;
      STOP:    if (bit_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shift_en = (state == DATA) && bit_end;
    byte_ok  = (state == STOP) && bit_end && rx_s;
    byte_err = (state == STOP) && bit_end && !rx_s;
  end

  // Leaving STOP mid-bit keeps the receiver ready for an immediately following start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync          <= 2'b11;
      cnt           <= '0;
      idx           <= '0;
      rx_data_valid <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_byte       <= '0;
    end else begin
      sync <= {sync[0], rx_serial};
      if ((state == IDLE) || (state_nxt != state) || bit_end) cnt <= '0;
      else                                                     cnt <= cnt + CNT_W'(1);
      if (state == START)                    idx <= '0;
      else if (shift_en && (idx != IDX_LAST)) idx <= idx + IDX_W'(1);
      rx_data_valid <= byte_ok;
      rx_frame_err  <= byte_err;
      if (byte_ok) rx_byte <= shreg;
    end
  end

  always_ff @(posedge clk) begin
    if (shift_en) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
  end

endmodule

// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter: one byte per accepted request, LSB first, idle-high line.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tx_data_valid,
  input  logic [DATA_BITS-1:0] tx_byte,
  output logic                 tx_active,
  output logic                 tx_serial,
  output logic                 tx_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  uart_state_e          state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] tx_data_q;
  logic                 bit_end;
  logic                 accept;

  assign bit_end = (cnt == CNT_LAST);
  assign accept  = (state == IDLE) && tx_data_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tx_data_valid) state_nxt = START;
      START:   if (bit_end) state_nxt = DATA;
      DATA:    if (bit_end && (idx == IDX_LAST)) state_nxt = STOP;
      STOP:    if (bit_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_serial = 1'b1;
    tx_active = 1'b1;
    case (state)
      IDLE:    tx_active = 1'b0;
      START:   tx_serial = 1'b0;
      DATA:    tx_serial = tx_data_q[idx];
      default: ;
    endcase
  end

  // Bit timing, bit index and the sticky completion flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      idx     <= '0;
      tx_done <= 1'b0;
    end else begin
      if ((state == IDLE) || bit_end) cnt <= '0;
      else                            cnt <= cnt + CNT_W'(1);
      if (state == START)                                  idx <= '0;
      else if ((state == DATA) && bit_end && (idx != IDX_LAST)) idx <= idx + IDX_W'(1);
      if (accept)                           tx_done <= 1'b0;
      else if ((state == STOP) && bit_end)  tx_done <= 1'b1;
    end
  end

  // Byte is latched only on accept, so later tx_byte changes never reach the line.
  always_ff @(posedge clk) begin
    if (accept) tx_data_q <= tx_byte;
  end

endmodule

// File: rtl/uart_txrx_core.sv
// 8N1 UART transmitter/receiver pair; the two directions run fully independently.
module uart_txrx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tx_data_valid,
  input  logic [DATA_BITS-1:0] tx_byte,
  output logic                 tx_active,
  output logic                 tx_serial,
  output logic                 tx_done,
  input  logic                 rx_serial,
  output logic                 rx_data_valid,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 rx_frame_err
);

  uart_tx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk           (clk),
    .reset_n       (reset_n),
    .tx_data_valid (tx_data_valid),
    .tx_byte       (tx_byte),
    .tx_active     (tx_active),
    .tx_serial     (tx_serial),
    .tx_done       (tx_done)
  );

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk           (clk),
    .reset_n       (reset_n),
    .rx_serial     (rx_serial),
    .rx_data_valid (rx_data_valid),
    .rx_byte       (rx_byte),
    .rx_frame_err  (rx_frame_err)
  );

endmodule

// File: tb/tb_uart_txrx_core.sv
// Directed bench for uart_txrx_core at 16 clocks per bit, with optional TX->RX loopback.
module tb_uart_txrx_core;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tx_data_valid = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_active, tx_serial, tx_done;
  logic       rx_data_valid, rx_frame_err;
  logic [7:0] rx_byte;
  logic       loop = 1'b0;
  logic       rx_drv = 1'b1;
  logic       rx_line;

  int checks = 0;
  int passes = 0;
  int rx_valid_cnt = 0;
  int rx_err_cnt = 0;
  logic [7:0] rxq[$];

  assign rx_line = loop ? tx_serial : rx_drv;

  always #5 clk = ~clk;

  uart_txrx_core #(.CLKS_PER_BIT(16)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .tx_data_valid (tx_data_valid),
    .tx_byte       (tx_byte),
    .tx_active     (tx_active),
    .tx_serial     (tx_serial),
    .tx_done       (tx_done),
    .rx_serial     (rx_line),
    .rx_data_valid (rx_data_valid),
    .rx_byte       (rx_byte),
    .rx_frame_err  (rx_frame_err)
  );

  always @(negedge clk) begin
    if (rx_data_valid === 1'b1) begin
      rx_valid_cnt++;
      rxq.push_back(rx_byte);
    end
    if (rx_frame_err === 1'b1) rx_err_cnt++;
  end

  task automatic drive_rx_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx_drv = f[k];
      repeat (16) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (tx_serial !== 1'b1) $display("FAIL rst_tx_serial got %b want 1", tx_serial); else passes++;
    checks++; if (tx_active !== 1'b0) $display("FAIL rst_tx_active got %b want 0", tx_active); else passes++;
    checks++; if (tx_done !== 1'b0) $display("FAIL rst_tx_done got %b want 0", tx_done); else passes++;
    checks++; if (rx_data_valid !== 1'b0) $display("FAIL rst_rx_valid got %b want 0", rx_data_valid); else passes++;
    checks++; if (rx_byte !== 8'h00) $display("FAIL rst_rx_byte got %h want 00", rx_byte); else passes++;
    checks++; if (rx_frame_err !== 1'b0) $display("FAIL rst_rx_err got %b want 0", rx_frame_err); else passes++;
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (tx_serial !== 1'b1) $display("FAIL idle_tx_serial got %b want 1", tx_serial); else passes++;
  endtask

  task automatic test_loopback;
    int cyc;
    int v0;
    loop = 1'b1;
    v0 = rx_valid_cnt;
    @(negedge clk); tx_byte = 8'hA5; tx_data_valid = 1'b1;
    @(negedge clk); tx_data_valid = 1'b0; cyc = 0;
    checks++; if (tx_active !== 1'b1) $display("FAIL lb_active got %b want 1", tx_active); else passes++;
    checks++; if (tx_serial !== 1'b0) $display("FAIL lb_start_bit got %b want 0", tx_serial); else passes++;
    while (tx_done !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (cyc !== 160) $display("FAIL lb_done_latency got %0d want 160", cyc); else passes++;
    repeat (4) @(negedge clk);
    checks++; if (rx_valid_cnt - v0 !== 1) $display("FAIL lb_strobes got %0d want 1", rx_valid_cnt - v0); else passes++;
    checks++; if (rx_byte !== 8'hA5) $display("FAIL lb_rx_byte got %h want a5", rx_byte); else passes++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes[3] = '{8'h00, 8'hFF, 8'h01};
    logic [9:0] f;
    int cyc;
    int v0;
    loop = 1'b1;
    v0 = rx_valid_cnt;
    rxq.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); tx_byte = bytes[i]; tx_data_valid = 1'b1;
      @(negedge clk); tx_data_valid = 1'b0;
      f = {1'b1, bytes[i], 1'b0};
      repeat (8) @(negedge clk);
      for (int k = 0; k < 10; k++) begin
        checks++; if (tx_serial !== f[k]) $display("FAIL b2b_line byte%0d bit%0d got %b want %b", i, k, tx_serial, f[k]); else passes++;
        if (k < 9) repeat (16) @(negedge clk);
      end
      cyc = 0;
      while (tx_done !== 1'b1 && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      checks++; if (tx_done !== 1'b1) $display("FAIL b2b_done byte%0d got %b want 1", i, tx_done); else passes++;
    end
    repeat (4) @(negedge clk);
    checks++; if (rx_valid_cnt - v0 !== 3) $display("FAIL b2b_strobes got %0d want 3", rx_valid_cnt - v0); else passes++;
    for (int i = 0; i < 3; i++) begin
      checks++; if (rxq[i] !== bytes[i]) $display("FAIL b2b_rx_byte%0d got %h want %h", i, rxq[i], bytes[i]); else passes++;
    end
  endtask

  task automatic test_glitch;
    int v0;
    int e0;
    loop = 1'b0;
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    v0 = rx_valid_cnt;
    e0 = rx_err_cnt;
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (rx_valid_cnt !== v0) $display("FAIL glitch_valid got %0d want %0d", rx_valid_cnt, v0); else passes++;
    checks++; if (rx_err_cnt !== e0) $display("FAIL glitch_err got %0d want %0d", rx_err_cnt, e0); else passes++;
    drive_rx_frame(8'h3C, 1'b1);
    repeat (20) @(negedge clk);
    checks++; if (rx_valid_cnt - v0 !== 1) $display("FAIL glitch_next_strobes got %0d want 1", rx_valid_cnt - v0); else passes++;
    checks++; if (rx_byte !== 8'h3C) $display("FAIL glitch_next_byte got %h want 3c", rx_byte); else passes++;
  endtask

  task automatic test_frame_err;
    int v0;
    int e0;
    loop = 1'b0;
    v0 = rx_valid_cnt;
    e0 = rx_err_cnt;
    drive_rx_frame(8'h99, 1'b0);
    repeat (40) @(negedge clk);
    checks++; if (rx_err_cnt - e0 !== 1) $display("FAIL ferr_strobes got %0d want 1", rx_err_cnt - e0); else passes++;
    checks++; if (rx_valid_cnt !== v0) $display("FAIL ferr_valid got %0d want %0d", rx_valid_cnt, v0); else passes++;
    checks++; if (rx_byte !== 8'h3C) $display("FAIL ferr_rx_byte got %h want 3c", rx_byte); else passes++;
  endtask

  task automatic test_hold_valid;
    int act;
    int v0;
    loop = 1'b1;
    act = 0;
    v0 = rx_valid_cnt;
    @(negedge clk); tx_byte = 8'h96; tx_data_valid = 1'b1;
    for (int cyc = 1; cyc <= 250; cyc++) begin
      @(negedge clk);
      if (cyc == 5) tx_byte = 8'h69;
      if (cyc == 50) tx_data_valid = 1'b0;
      if (tx_active === 1'b1) act++;
    end
    checks++; if (act !== 160) $display("FAIL hold_active_cycles got %0d want 160", act); else passes++;
    checks++; if (rx_valid_cnt - v0 !== 1) $display("FAIL hold_strobes got %0d want 1", rx_valid_cnt - v0); else passes++;
    checks++; if (rx_byte !== 8'h96) $display("FAIL hold_rx_byte got %h want 96", rx_byte); else passes++;
    checks++; if (tx_done !== 1'b1) $display("FAIL hold_done got %b want 1", tx_done); else passes++;
  endtask

  task automatic test_reset_midframe;
    logic [9:0] f;
    int v0;
    int e0;
    int cyc;
    loop = 1'b0;
    f = {1'b1, 8'hC3, 1'b0};
    v0 = rx_valid_cnt;
    e0 = rx_err_cnt;
    @(negedge clk); tx_byte = 8'hC3; tx_data_valid = 1'b1; rx_drv = f[0];
    for (int c = 1; c <= 88; c++) begin
      @(negedge clk);
      if (c == 1) tx_data_valid = 1'b0;
      rx_drv = f[c / 16];
    end
    checks++; if (tx_active !== 1'b1) $display("FAIL mid_active_before got %b want 1", tx_active); else passes++;
    reset_n = 1'b0;
    #1;
    checks++; if (tx_serial !== 1'b1) $display("FAIL mid_rst_tx_serial got %b want 1", tx_serial); else passes++;
    checks++; if (tx_active !== 1'b0) $display("FAIL mid_rst_tx_active got %b want 0", tx_active); else passes++;
    checks++; if (tx_done !== 1'b0) $display("FAIL mid_rst_tx_done got %b want 0", tx_done); else passes++;
    checks++; if (rx_byte !== 8'h00) $display("FAIL mid_rst_rx_byte got %h want 00", rx_byte); else passes++;
    checks++; if (rx_data_valid !== 1'b0) $display("FAIL mid_rst_rx_valid got %b want 0", rx_data_valid); else passes++;
    checks++; if (rx_frame_err !== 1'b0) $display("FAIL mid_rst_rx_err got %b want 0", rx_frame_err); else passes++;
    rx_drv = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    checks++; if (rx_valid_cnt !== v0 || rx_err_cnt !== e0) $display("FAIL mid_no_strobes got %0d/%0d want %0d/%0d", rx_valid_cnt, rx_err_cnt, v0, e0); else passes++;
    loop = 1'b1;
    @(negedge clk); tx_byte = 8'h5A; tx_data_valid = 1'b1;
    @(negedge clk); tx_data_valid = 1'b0; cyc = 0;
    while (tx_done !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (cyc !== 160) $display("FAIL mid_resend_latency got %0d want 160", cyc); else passes++;
    repeat (4) @(negedge clk);
    checks++; if (rx_valid_cnt - v0 !== 1) $display("FAIL mid_resend_strobes got %0d want 1", rx_valid_cnt - v0); else passes++;
    checks++; if (rx_byte !== 8'h5A) $display("FAIL mid_resend_byte got %h want 5a", rx_byte); else passes++;
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_hold_valid();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
